// File: rtl/ram_hor.sv
// ram_hor: single-port synchronous RAM with registered read data and a
// read-valid strobe. Reset clears the storage as well as the outputs.
module ram_hor #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d,
   input  logic [ADDR_W-1:0] addr,
   input  logic              cs,
   input  logic              rw,
   output logic [DATA_W-1:0] o,
   output logic              rd_valid
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;
   logic              wr_en;
   logic              rd_en;

   // Codes at or above DEPTH have no storage behind them.
   assign in_range = (int'(addr) < DEPTH);
   assign wr_en    = cs & ~rw;
   assign rd_en    = cs &  rw;

   // Storage: cleared by reset, written on a selected write cycle.
   // NOTE: the array is reset word by word, so it maps to flops rather than
   // a RAM macro; that is the price of guaranteeing all-zero contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && in_range) begin
         // NOTE: non-blocking so every register in this block updates from
         // values sampled at the same edge.
         mem[addr] <= d;
      end
   end

   // Read port: o only changes on a selected read and otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o        <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            o <= in_range ? mem[addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_ram_hor.sv
// tb_ram_hor: directed stimulus for ram_hor. Reads push their expected data
// into a queue; a monitor pops it whenever rd_valid is seen.
module tb_ram_hor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] d;
   logic [3:0] addr;
   logic       cs;
   logic       rw;
   logic [7:0] o;
   logic       rd_valid;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic [7:0] hold_o = 8'h00;
   logic       exp_rv;

   ram_hor #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d        (d),
      .addr     (addr),
      .cs       (cs),
      .rw       (rw),
      .o        (o),
      .rd_valid (rd_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs on the falling edge.
   task automatic cyc(input logic c, input logic r, input logic [3:0] a, input logic [7:0] dv);
      @(negedge clk);
      cs   = c;
      rw   = r;
      addr = a;
      d    = dv;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] dv);
      cyc(1'b1, 1'b0, a, dv);
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] e);
      cyc(1'b1, 1'b1, a, 8'($urandom));
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic r, input logic [3:0] a, input logic [7:0] dv);
      cyc(1'b0, r, a, dv);
   endtask

   // Any reset clears the data the output is expected to hold.
   always @(negedge rst_n) hold_o = 8'h00;

   // Monitor: check rd_valid every cycle, then either pop a read result or
   // confirm that o held its previous value.
   always @(posedge clk) begin
      exp_rv = rst_n && cs && rw;
      #1;
      check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read", 32'd1, 32'd0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("o_read", {24'd0, o}, {24'd0, e});
            hold_o = e;
         end
      end else begin
         check("o_hold", {24'd0, o}, {24'd0, hold_o});
      end
   end

   initial begin
      rst_n = 1'b0;
      cs    = 1'b0;
      rw    = 1'b0;
      addr  = 4'h0;
      d     = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_o", {24'd0, o}, 32'd0);
      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      rst_n = 1'b1;

      // Write then read back at the address extremes.
      wr(4'hF, 8'hFF);
      wr(4'h0, 8'h00);
      rd(4'hF, 8'hFF);
      rd(4'h0, 8'h00);

      // A deselected write must not land.
      wr(4'h3, 8'hA5);
      idle(1'b0, 4'h3, 8'h5A);
      rd(4'h3, 8'hA5);

      // o holds across writes and deselected cycles.
      rd(4'hF, 8'hFF);
      wr(4'h1, 8'h11);
      idle(1'b1, 4'h0, 8'h00);
      wr(4'h2, 8'h22);
      idle(1'b0, 4'h3, 8'h99);
      idle(1'b1, 4'hF, 8'h00);

      // Asynchronous reset between edges, with a write attempted under it.
      @(negedge clk);
      cs = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_o", {24'd0, o}, 32'd0);
      check("async_rd_valid", {31'd0, rd_valid}, 32'd0);
      cs   = 1'b1;
      rw   = 1'b0;
      addr = 4'h5;
      d    = 8'h77;
      @(negedge clk);
      cs    = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);

      // Full sweep with a distinct pattern per address.
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(i) ^ 8'h3C);
      for (int i = 0; i < 16; i++) rd(4'(i), 8'(i) ^ 8'h3C);

      // Drain: every issued read must have been observed.
      idle(1'b0, 4'h0, 8'h00);
      repeat (3) @(negedge clk);
      check("reads_outstanding", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_hor.md
RAM_HOR -- requirements
Module: ram_hor

Interface
- REQ-001: The block SHALL expose parameter DATA_W, default 8, data word width in bits.
- REQ-002: The block SHALL expose parameter ADDR_W, default 4, address width in bits.
- REQ-003: The block SHALL expose parameter DEPTH, default 2**ADDR_W (16), number of words.
- REQ-004: The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-005: The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-006: The block SHALL have port d, input, DATA_W bits: write data.
- REQ-007: The block SHALL have port addr, input, ADDR_W bits: word address for read and write.
- REQ-008: The block SHALL have port cs, input, 1 bit: chip select, active high.
- REQ-009: The block SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
- REQ-010: The block SHALL have port o, output, DATA_W bits: registered read data.
- REQ-011: The block SHALL have port rd_valid, output, 1 bit: high for the cycle after a read was accepted.

Function
- REQ-012: Storage SHALL be DEPTH words of DATA_W bits, indexed by addr.
- REQ-013: Write: on a rising clk edge with cs=1 and rw=0, mem[addr] SHALL be loaded with d; o SHALL hold its value.
- REQ-014: Read: on a rising clk edge with cs=1 and rw=1, o SHALL be loaded with mem[addr]; latency is 1 edge, so o is valid after that edge.
- REQ-015: With cs=0, no memory word, o, or any other state SHALL change, regardless of rw, addr, or d.
- REQ-016: Between reads, o SHALL hold the last value read; it SHALL NOT follow addr combinationally.
- REQ-017: rd_valid SHALL be registered: 1 after an edge where cs=1 and rw=1, 0 after any other edge.
- REQ-018: A read of an address written on an earlier edge SHALL return the written data.
- REQ-019: A read and a write in the same cycle are impossible, because rw selects one operation.
- REQ-020: Back-to-back reads on consecutive edges SHALL each update o; no idle cycle is required.
- REQ-021: Addresses SHALL NOT wrap or saturate; all 2**ADDR_W codes are valid when DEPTH = 2**ADDR_W.
- REQ-022: If DEPTH < 2**ADDR_W, writes to out-of-range addresses SHALL be ignored and reads from them SHALL return 0.
- REQ-023: A d value wider than DATA_W at the source SHALL be truncated to its low DATA_W bits by connection; the block performs no width checks.
- REQ-024: Inputs SHALL be sampled only at the rising clk edge; changes between edges have no effect.

Reset
- REQ-025: When rst_n=0, o SHALL go to 0 and rd_valid to 0 immediately, independent of clk.
- REQ-026: When rst_n=0, every memory word SHALL be cleared to 0.
- REQ-027: While rst_n=0, writes and reads SHALL be blocked.
- REQ-028: Normal operation SHALL resume on the first rising clk edge after rst_n returns to 1.
- REQ-029: Asserting rst_n mid-operation SHALL discard any operation on that edge; the subsequent state is all zeros.

Verification
- REQ-030: Write then read back: write d=0xFF to addr 0xF, write 0x00 to addr 0x0, read addr 0xF, read addr 0x0 -> o=0xFF then o=0x00, with rd_valid=1 after each read edge.
- REQ-031: Chip-select gating: write 0xA5 to addr 3, then attempt to write 0x5A to addr 3 with cs=0, then read addr 3 -> o=0xA5.
- REQ-032: Output hold: read addr 0xF (o=0xFF), then perform writes and cs=0 cycles -> o stays 0xFF and rd_valid=0.
- REQ-033: Asynchronous reset: after loading several words, pulse rst_n low between clock edges -> o=0 at once; subsequent reads of all 16 addresses return 0x00.
- REQ-034: Full sweep: write addr value XOR 0x3C to each of addrs 0..15, read them back in order -> each o matches, one edge latency per read.
